// File: rtl/stack_pkg.sv
// Shared definitions for the stack_8x4 initiator: FSM state encoding, nibble width, default depth.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro STACK_CALL_SEQ_FLUSH_EN uses the ST_FLUSH encoding defined here.
package stack_pkg;

  localparam int NIBBLE_W            = 4;
  localparam int DEFAULT_STACK_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PUSH  = 3'd1,
    ST_POP   = 3'd2,
    ST_FIN   = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  // Width of a nibble index; never zero so a one-nibble address still has a legal vector.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/stack_depth_ctr.sv
// Saturating up/down occupancy counter mirroring the attached stack, with room/content compares.
// Latency: depth updates on the clock edge after inc/dec; can_push/can_pop are combinational off depth.
// Backpressure: none; inc at full or dec at empty is ignored (saturates).
// Ports: clk, reset (async active-low), inc, dec, depth, can_push (depth+NIB<=STACK_DEPTH), can_pop (depth>=NIB).
import stack_pkg::*;

module stack_depth_ctr #(
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH,
  parameter int NIB         = 2,
  parameter int DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] depth,
  output logic          can_push,
  output logic          can_pop
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth <= '0;
    end else if (inc && !dec && (depth != DW'(STACK_DEPTH))) begin
      depth <= depth + 1'b1;
    end else if (dec && !inc && (depth != '0)) begin
      depth <= depth - 1'b1;
    end
  end

  assign can_push = (int'(depth) + NIB) <= STACK_DEPTH;
  assign can_pop  = int'(depth) >= NIB;

endmodule

// File: rtl/stack_call_seq.sv
// CALL/RET sequencer driving stack_8x4: pushes a return address low nibble first, pops it back on RET.
// Latency: accept edge, NIB push/pop cycles, then done/ret_valid pulse in cycle NIB+1 after accept.
// Backpressure: requests only sampled in IDLE (busy=0); rejected CALL/RET pulse overflow/underflow.
// Ports: clk, reset (async active-low, shared with stack), call_req/call_addr, ret_req, busy, done,
//        ret_valid/ret_addr, overflow, underflow, depth, stk_en/stk_we/stk_wdata, stk_rdata.
// Optional: STACK_CALL_SEQ_FLUSH_EN adds input flush and a FLUSH state that empties the stack.
import stack_pkg::*;

module stack_call_seq #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
`ifdef STACK_CALL_SEQ_FLUSH_EN
  input  logic                             flush,
`endif
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             call_req,
  input  logic [ADDR_W-1:0]                call_addr,
  input  logic                             ret_req,
  output logic                             busy,
  output logic                             done,
  output logic                             ret_valid,
  output logic [ADDR_W-1:0]                ret_addr,
  output logic                             overflow,
  output logic                             underflow,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             stk_en,
  output logic                             stk_we,
  output logic [NIBBLE_W-1:0]              stk_wdata,
  input  logic [NIBBLE_W-1:0]              stk_rdata
);

  localparam int NIB = ADDR_W / NIBBLE_W;
  localparam int IW  = idx_width(NIB);
  localparam int DW  = $clog2(STACK_DEPTH + 1);

  state_t              state, state_n;
  logic [IW-1:0]       idx, idx_n;
  logic [ADDR_W-1:0]   addr_q, addr_n;
  logic                is_ret, is_ret_n;
  logic                inc, dec;
  logic                can_push, can_pop;

  logic                busy_n, done_n, ret_valid_n, overflow_n, underflow_n;
  logic                stk_en_n, stk_we_n;
  logic [NIBBLE_W-1:0] stk_wdata_n;

  stack_depth_ctr #(
    .STACK_DEPTH(STACK_DEPTH),
    .NIB        (NIB),
    .DW         (DW)
  ) u_depth (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc),
    .dec     (dec),
    .depth   (depth),
    .can_push(can_push),
    .can_pop (can_pop)
  );

  // Next-state logic. Command outputs are registered, so they are derived from the
  // state the FSM is about to enter rather than the current one.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    addr_n      = addr_q;
    is_ret_n    = is_ret;
    inc         = 1'b0;
    dec         = 1'b0;
    overflow_n  = 1'b0;
    underflow_n = 1'b0;

    unique case (state)
      ST_IDLE: begin
`ifdef STACK_CALL_SEQ_FLUSH_EN
        if (flush) begin
          is_ret_n = 1'b0;
          state_n  = (depth == '0) ? ST_FIN : ST_FLUSH;
        end else
`endif
        if (call_req) begin
          // ret_req in the same cycle is dropped: CALL wins.
          if (can_push) begin
            addr_n   = call_addr;
            idx_n    = '0;
            is_ret_n = 1'b0;
            state_n  = ST_PUSH;
          end else begin
            overflow_n = 1'b1;
          end
        end else if (ret_req) begin
          if (can_pop) begin
            idx_n    = IW'(NIB - 1);
            is_ret_n = 1'b1;
            state_n  = ST_POP;
          end else begin
            underflow_n = 1'b1;
          end
        end
      end
      ST_PUSH: begin
        inc = 1'b1;
        if (idx == IW'(NIB - 1)) state_n = ST_FIN;
        else                     idx_n   = idx + 1'b1;
      end
      ST_POP: begin
        dec = 1'b1;
        if (idx == '0) state_n = ST_FIN;
        else           idx_n   = idx - 1'b1;
      end
`ifdef STACK_CALL_SEQ_FLUSH_EN
      ST_FLUSH: begin
        // The pop in this cycle takes the last entry when depth is 1.
        dec = 1'b1;
        if (depth <= DW'(1)) state_n = ST_FIN;
      end
`endif
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    busy_n      = (state_n != ST_IDLE);
    done_n      = (state_n == ST_FIN) && !is_ret_n;
    ret_valid_n = (state_n == ST_FIN) &&  is_ret_n;
    stk_en_n    = (state_n == ST_PUSH) || (state_n == ST_POP)
`ifdef STACK_CALL_SEQ_FLUSH_EN
               || (state_n == ST_FLUSH)
`endif
               ;
    stk_we_n    = (state_n == ST_PUSH);
    stk_wdata_n = addr_n[NIBBLE_W*int'(idx_n) +: NIBBLE_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      addr_q    <= '0;
      is_ret    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ret_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      stk_en    <= 1'b0;
      stk_we    <= 1'b0;
      stk_wdata <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      addr_q    <= addr_n;
      is_ret    <= is_ret_n;
      busy      <= busy_n;
      done      <= done_n;
      ret_valid <= ret_valid_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
      stk_en    <= stk_en_n;
      stk_we    <= stk_we_n;
      stk_wdata <= stk_wdata_n;
    end
  end

  // Popped nibbles land in place as they come off the stack, high nibble first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ret_addr <= '0;
    end else if (state == ST_POP) begin
      ret_addr[NIBBLE_W*int'(idx) +: NIBBLE_W] <= stk_rdata;
    end
  end

endmodule

// File: tb/tb_stack_call_seq.sv
// Bench for stack_call_seq: behavioural stack_8x4 model plus an address-level reference stack.
// Latency: checks every cycle of each transaction against the documented timing.
// Backpressure: injects stray requests while busy and expects them to be ignored.
module tb_stack_call_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       call_req, ret_req;
  logic [7:0] call_addr;
  logic       busy, done, ret_valid, overflow, underflow;
  logic [7:0] ret_addr;
  logic [3:0] depth;
  logic       stk_en, stk_we;
  logic [3:0] stk_wdata, stk_rdata;
`ifdef STACK_CALL_SEQ_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Address-level reference: whole return addresses, newest at the back.
  logic [7:0] ref_q[$];
  logic [7:0] ref_ret = 8'h00;

  always #5 clk = ~clk;

  stack_call_seq dut (
`ifdef STACK_CALL_SEQ_FLUSH_EN
    .flush    (flush),
`endif
    .clk      (clk),
    .reset    (reset),
    .call_req (call_req),
    .call_addr(call_addr),
    .ret_req  (ret_req),
    .busy     (busy),
    .done     (done),
    .ret_valid(ret_valid),
    .ret_addr (ret_addr),
    .overflow (overflow),
    .underflow(underflow),
    .depth    (depth),
    .stk_en   (stk_en),
    .stk_we   (stk_we),
    .stk_wdata(stk_wdata),
    .stk_rdata(stk_rdata)
  );

  // Behavioural 8 x 4-bit stack.
  logic [3:0] smem [0:7];
  int         sp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp <= 0;
    end else if (stk_en) begin
      if (stk_we) begin
        if (sp < 8) begin
          smem[sp] <= stk_wdata;
          sp       <= sp + 1;
        end
      end else if (sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  always_comb stk_rdata = (sp > 0) ? smem[sp-1] : 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".done"},      32'(done),      32'd0);
    chk({tag, ".ret_valid"}, 32'(ret_valid), 32'd0);
    chk({tag, ".ret_addr"},  32'(ret_addr),  32'd0);
    chk({tag, ".overflow"},  32'(overflow),  32'd0);
    chk({tag, ".underflow"}, 32'(underflow), 32'd0);
    chk({tag, ".depth"},     32'(depth),     32'd0);
    chk({tag, ".stk_en"},    32'(stk_en),    32'd0);
    chk({tag, ".stk_we"},    32'(stk_we),    32'd0);
    chk({tag, ".stk_wdata"}, 32'(stk_wdata), 32'd0);
  endtask

  // One request from IDLE (call c and/or ret r), checked cycle by cycle.
  // With noise set, random requests are raised while busy; they must be ignored.
  task automatic do_op(input bit c, input bit r, input logic [7:0] a, input bit noise);
    int         nd;
    bit         acc_call, acc_ret, rej_call, rej_ret;
    logic [7:0] exp_ret;
    nd       = 2 * ref_q.size();
    acc_call = c && (nd + 2 <= 8);
    rej_call = c && !acc_call;
    acc_ret  = !c && r && (nd >= 2);
    rej_ret  = !c && r && !acc_ret;
    exp_ret  = ref_ret;
    if (acc_call) ref_q.push_back(a);
    if (acc_ret) begin
      exp_ret = ref_q.pop_back();
      ref_ret = exp_ret;
    end

    call_req = c; ret_req = r; call_addr = a;
    @(negedge clk);
    if (acc_call || acc_ret) begin
      chk("c1.busy",   32'(busy),   32'd1);
      chk("c1.stk_en", 32'(stk_en), 32'd1);
      chk("c1.stk_we", 32'(stk_we), 32'(acc_call));
      if (acc_call) chk("c1.wdata_lo", 32'(stk_wdata), 32'(a[3:0]));
      chk("c1.depth",  32'(depth),  32'(nd));
      call_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ret_req  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      call_addr = 8'($urandom);
      @(negedge clk);
      chk("c2.stk_en", 32'(stk_en), 32'd1);
      chk("c2.stk_we", 32'(stk_we), 32'(acc_call));
      if (acc_call) chk("c2.wdata_hi", 32'(stk_wdata), 32'(a[7:4]));
      chk("c2.depth",  32'(depth),  acc_call ? 32'(nd + 1) : 32'(nd - 1));
      call_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ret_req  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("c3.busy",      32'(busy),      32'd1);
      chk("c3.stk_en",    32'(stk_en),    32'd0);
      chk("c3.done",      32'(done),      32'(acc_call));
      chk("c3.ret_valid", 32'(ret_valid), 32'(acc_ret));
      if (acc_ret) chk("c3.ret_addr", 32'(ret_addr), 32'(exp_ret));
      chk("c3.depth",     32'(depth),     32'(2 * ref_q.size()));
      call_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ret_req  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      call_req = 1'b0; ret_req = 1'b0;
      chk("c4.busy",      32'(busy),      32'd0);
      chk("c4.done",      32'(done),      32'd0);
      chk("c4.ret_valid", 32'(ret_valid), 32'd0);
      chk("c4.depth",     32'(depth),     32'(2 * ref_q.size()));
    end else begin
      call_req = 1'b0; ret_req = 1'b0;
      chk("rej.overflow",  32'(overflow),  32'(rej_call));
      chk("rej.underflow", 32'(underflow), 32'(rej_ret));
      chk("rej.stk_en",    32'(stk_en),    32'd0);
      chk("rej.busy",      32'(busy),      32'd0);
      chk("rej.ret_addr",  32'(ret_addr),  32'(ref_ret));
      chk("rej.depth",     32'(depth),     32'(nd));
      @(negedge clk);
      chk("rej2.overflow",  32'(overflow),  32'd0);
      chk("rej2.underflow", 32'(underflow), 32'd0);
      chk("rej2.stk_en",    32'(stk_en),    32'd0);
    end
  endtask

`ifdef STACK_CALL_SEQ_FLUSH_EN
  task automatic do_flush();
    int nd;
    nd = 2 * ref_q.size();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < nd; i++) begin
      chk("fl.stk_en", 32'(stk_en), 32'd1);
      chk("fl.stk_we", 32'(stk_we), 32'd0);
      chk("fl.done",   32'(done),   32'd0);
      @(negedge clk);
    end
    chk("fl.done_pulse", 32'(done),      32'd1);
    chk("fl.ret_valid",  32'(ret_valid), 32'd0);
    chk("fl.ret_addr",   32'(ret_addr),  32'(ref_ret));
    chk("fl.stk_en_end", 32'(stk_en),    32'd0);
    ref_q.delete();
    @(negedge clk);
    chk("fl.depth0", 32'(depth), 32'd0);
    chk("fl.done0",  32'(done),  32'd0);
    chk("fl.busy0",  32'(busy),  32'd0);
  endtask
`endif

  initial begin
    reset = 1'b0; call_req = 1'b0; ret_req = 1'b0; call_addr = 8'h00;
    repeat (3) @(negedge clk);
    chk_idle_zero("rst");
    reset = 1'b1;
    @(negedge clk);
    chk_idle_zero("post_rst");

    // Single CALL: nibbles C then 3, done in 3rd cycle, depth 2.
    do_op(1'b1, 1'b0, 8'h3C, 1'b0);
    // Second CALL then two RETs in LIFO order.
    do_op(1'b1, 1'b0, 8'hA5, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("lifo.depth_end", 32'(depth), 32'd0);

    // Fill to 8 nibbles, overflow on the fifth CALL, then RET returns 0x44.
    do_op(1'b1, 1'b0, 8'h11, 1'b0);
    do_op(1'b1, 1'b0, 8'h22, 1'b0);
    do_op(1'b1, 1'b0, 8'h33, 1'b0);
    do_op(1'b1, 1'b0, 8'h44, 1'b0);
    do_op(1'b1, 1'b0, 8'h55, 1'b0);
    chk("ovf.depth_full", 32'(depth), 32'd8);
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("ovf.ret_44", 32'(ret_addr), 32'h44);
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 1'b0);

    // Underflow at depth 0 keeps ret_addr (0x11).
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf.ret_keep", 32'(ret_addr), 32'h11);

    // Simultaneous requests at depth 2: CALL wins; stray requests while busy ignored.
    do_op(1'b1, 1'b0, 8'h12, 1'b0);
    do_op(1'b1, 1'b1, 8'h9B, 1'b1);
    chk("prio.depth4", 32'(depth), 32'd4);

    // Reset in the middle of a CALL.
    ref_q.delete();
    ref_ret = 8'h00;
    call_req = 1'b1; call_addr = 8'h7E;
    @(negedge clk);
    call_req = 1'b0;
    chk("mid.stk_en_before", 32'(stk_en), 32'd1);
    #2 reset = 1'b0;
    #1 chk_idle_zero("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_zero("mid_rel");
    do_op(1'b1, 1'b0, 8'h5A, 1'b0);
    do_op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("mid.ret_5a", 32'(ret_addr), 32'h5A);

`ifdef STACK_CALL_SEQ_FLUSH_EN
    do_op(1'b1, 1'b0, 8'h21, 1'b0);
    do_op(1'b1, 1'b0, 8'h43, 1'b0);
    do_op(1'b1, 1'b0, 8'h65, 1'b0);
    chk("fl.depth6", 32'(depth), 32'd6);
    do_flush();
    do_flush();
`endif

    // Randomized traffic against the reference stack.
    for (int i = 0; i < 300; i++) begin
      bit c, r;
      c = ($urandom_range(0, 99) < 55);
      r = !c || ($urandom_range(0, 3) == 0);
      do_op(c, r, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
